// File: rtl/pisa_mem_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, requester identity,
// access-size encodings and the latched request record.
package pisa_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } arb_owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  typedef struct packed {
    arb_owner_t  owner;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and load/store requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise LS has fixed priority.
module mem_arb_grant
  import pisa_mem_pkg::*;
(
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       accept_win,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    if (accept_win) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (if_valid && ls_valid) begin
        if (arb_owner_t'(last_owner) == OWNER_IF) grant[GNT_LS] = 1'b1;
        else                                      grant[GNT_IF] = 1'b1;
      end else begin
        grant[GNT_IF] = if_valid;
        grant[GNT_LS] = ls_valid;
      end
`else
      if (ls_valid)      grant[GNT_LS] = 1'b1;
      else if (if_valid) grant[GNT_IF] = 1'b1;
`endif
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; the port stays for a uniform interface.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// IF/LS sequencer in front of the combinational memory-controller port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin grant; default is LS priority.
module mem_bus_arbiter
  import pisa_mem_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [31:0]          if_addr,
  output logic                 if_rsp_valid,
  output logic [31:0]          if_rsp_data,
  output logic                 if_rsp_error,
  input  logic                 ls_req_valid,
  output logic                 ls_req_ready,
  input  logic [31:0]          ls_addr,
  input  logic                 ls_we,
  input  logic [1:0]           ls_size,
  input  logic [31:0]          ls_wdata,
  output logic                 ls_rsp_valid,
  output logic [31:0]          ls_rsp_data,
  output logic                 ls_rsp_error,
  output logic [31:0]          mc_address,
  output logic                 mc_write_enable,
  output logic [1:0]           mc_data_in_size,
  output logic [1:0]           mc_data_out_size,
  output logic [31:0]          mc_data_in,
  input  logic [31:0]          mc_data_out,
  input  logic                 mc_memory_error,
  output logic [ERR_CNT_W-1:0] err_count
);

  arb_state_t           state_q, state_d;
  arb_req_t             req_q, req_d;
  logic                 last_owner_q, last_owner_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 if_rsp_valid_q, if_rsp_valid_d;
  logic                 ls_rsp_valid_q, ls_rsp_valid_d;
  logic                 if_rsp_error_q, if_rsp_error_d;
  logic                 ls_rsp_error_q, ls_rsp_error_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic       accept_win;
  logic       in_access;
  logic [1:0] grant;

  assign accept_win = (state_q == IDLE) || (state_q == RESP);
  assign in_access  = (state_q == ACCESS);

  mem_arb_grant u_grant (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .accept_win (accept_win),
    .last_owner (last_owner_q),
    .grant      (grant)
  );

  assign if_req_ready = grant[GNT_IF];
  assign ls_req_ready = grant[GNT_LS];

  // The controller only ever sees the latched request during ACCESS.
  assign mc_address       = in_access ? req_q.addr  : 32'h0;
  assign mc_data_in       = in_access ? req_q.wdata : 32'h0;
  assign mc_write_enable  = in_access & req_q.we;
  assign mc_data_in_size  = in_access ? req_q.size  : SIZE_WORD;
  assign mc_data_out_size = in_access ? req_q.size  : SIZE_WORD;

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = rsp_data_q;
  assign if_rsp_error = if_rsp_error_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign ls_rsp_data  = rsp_data_q;
  assign ls_rsp_error = ls_rsp_error_q;
  assign err_count    = err_count_q;

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    last_owner_d   = last_owner_q;
    rsp_data_d     = rsp_data_q;
    if_rsp_valid_d = 1'b0;
    ls_rsp_valid_d = 1'b0;
    if_rsp_error_d = 1'b0;
    ls_rsp_error_d = 1'b0;
    err_count_d    = err_count_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (grant[GNT_LS]) begin
          req_d.owner  = OWNER_LS;
          req_d.addr   = ls_addr;
          req_d.we     = ls_we;
          req_d.size   = ls_size;
          req_d.wdata  = ls_wdata;
          last_owner_d = OWNER_LS;
          state_d      = ACCESS;
        end else if (grant[GNT_IF]) begin
          req_d.owner  = OWNER_IF;
          req_d.addr   = if_addr;
          req_d.we     = 1'b0;
          req_d.size   = SIZE_WORD;
          req_d.wdata  = 32'h0;
          last_owner_d = OWNER_IF;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rsp_data_d = mc_data_out;
        if (req_q.owner == OWNER_IF) begin
          if_rsp_valid_d = 1'b1;
          if_rsp_error_d = mc_memory_error;
        end else begin
          ls_rsp_valid_d = 1'b1;
          ls_rsp_error_d = mc_memory_error;
        end
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase

    if ((if_rsp_error_q || ls_rsp_error_q) && (err_count_q != {ERR_CNT_W{1'b1}}))
      err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_q          <= '0;
      last_owner_q   <= OWNER_IF;
      rsp_data_q     <= 32'h0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_error_q <= 1'b0;
      ls_rsp_error_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      last_owner_q   <= last_owner_d;
      rsp_data_q     <= rsp_data_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      if_rsp_error_q <= if_rsp_error_d;
      ls_rsp_error_q <= ls_rsp_error_d;
      err_count_q    <= err_count_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural memory controller.
// Expected order under contention follows MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;
  import pisa_mem_pkg::*;

  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 if_req_valid = 1'b0;
  logic                 if_req_ready;
  logic [31:0]          if_addr = 32'h0;
  logic                 if_rsp_valid;
  logic [31:0]          if_rsp_data;
  logic                 if_rsp_error;
  logic                 ls_req_valid = 1'b0;
  logic                 ls_req_ready;
  logic [31:0]          ls_addr = 32'h0;
  logic                 ls_we = 1'b0;
  logic [1:0]           ls_size = SIZE_WORD;
  logic [31:0]          ls_wdata = 32'h0;
  logic                 ls_rsp_valid;
  logic [31:0]          ls_rsp_data;
  logic                 ls_rsp_error;
  logic [31:0]          mc_address;
  logic                 mc_write_enable;
  logic [1:0]           mc_data_in_size;
  logic [1:0]           mc_data_out_size;
  logic [31:0]          mc_data_in;
  logic [31:0]          mc_data_out;
  logic                 mc_memory_error;
  logic [ERR_CNT_W-1:0] err_count;

  mem_bus_arbiter #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req_valid     (if_req_valid),
    .if_req_ready     (if_req_ready),
    .if_addr          (if_addr),
    .if_rsp_valid     (if_rsp_valid),
    .if_rsp_data      (if_rsp_data),
    .if_rsp_error     (if_rsp_error),
    .ls_req_valid     (ls_req_valid),
    .ls_req_ready     (ls_req_ready),
    .ls_addr          (ls_addr),
    .ls_we            (ls_we),
    .ls_size          (ls_size),
    .ls_wdata         (ls_wdata),
    .ls_rsp_valid     (ls_rsp_valid),
    .ls_rsp_data      (ls_rsp_data),
    .ls_rsp_error     (ls_rsp_error),
    .mc_address       (mc_address),
    .mc_write_enable  (mc_write_enable),
    .mc_data_in_size  (mc_data_in_size),
    .mc_data_out_size (mc_data_out_size),
    .mc_data_in       (mc_data_in),
    .mc_data_out      (mc_data_out),
    .mc_memory_error  (mc_memory_error),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: writes below 0x80 (code region) are rejected with an error.
  logic [31:0] ctrl_mem [0:1023];
  assign mc_memory_error = mc_write_enable && (mc_address < 32'h80);
  assign mc_data_out     = mc_write_enable ? 32'h0 : ctrl_mem[mc_address[11:2]];
  always @(posedge clk)
    if (mc_write_enable && !mc_memory_error) ctrl_mem[mc_address[11:2]] = mc_data_in;

  typedef struct {
    arb_owner_t  owner;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_mem [0:1023];
  int          we_cycles[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic exp_t predict(arb_owner_t o, logic [31:0] a, logic we,
                                   logic [31:0] wd, int c);
    exp_t r;
    r.owner = o;
    r.cyc   = c;
    r.err   = we && (a < 32'h80);
    r.data  = we ? 32'h0 : exp_mem[a[11:2]];
    if (we && !r.err) exp_mem[a[11:2]] = wd;
    return r;
  endfunction

  // Scoreboard monitor: pop/compare responses, then push newly accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (mc_write_enable) we_cycles.push_back(cyc);
      if (if_rsp_valid && ls_rsp_valid) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rsp_both_valid: both response strobes high at cycle %0d", cyc);
      end else if (if_rsp_valid || ls_rsp_valid) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp_unexpected: response at cycle %0d with nothing outstanding", cyc);
        end else begin
          mon_e = sb.pop_front();
          if ((if_rsp_valid ? OWNER_IF : OWNER_LS) !== mon_e.owner ||
              (if_rsp_valid ? if_rsp_data : ls_rsp_data) !== mon_e.data ||
              (if_rsp_valid ? if_rsp_error : ls_rsp_error) !== mon_e.err ||
              cyc !== mon_e.cyc + 2) begin
            tests_failed++;
            $display("FAIL rsp_compare: got owner=%0d data=%h err=%0b cyc=%0d, expected owner=%0d data=%h err=%0b cyc=%0d",
                     if_rsp_valid ? 0 : 1, if_rsp_valid ? if_rsp_data : ls_rsp_data,
                     if_rsp_valid ? if_rsp_error : ls_rsp_error, cyc,
                     mon_e.owner, mon_e.data, mon_e.err, mon_e.cyc + 2);
          end
        end
      end else if (sb.size() != 0 && cyc >= sb[0].cyc + 2) begin
        tests_run++;
        tests_failed++;
        mon_e = sb.pop_front();
        $display("FAIL rsp_missing: no response at cycle %0d, expected at %0d", cyc, mon_e.cyc + 2);
      end

      if (if_req_ready && ls_req_ready) begin
        tests_run++;
        tests_failed++;
        $display("FAIL ready_both: both readies high at cycle %0d", cyc);
      end
      if (ls_req_valid && ls_req_ready)
        sb.push_back(predict(OWNER_LS, ls_addr, ls_we, ls_wdata, cyc));
      else if (if_req_valid && if_req_ready)
        sb.push_back(predict(OWNER_IF, if_addr, 1'b0, 32'h0, cyc));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input arb_owner_t who, input logic [31:0] addr, input logic we,
                       input logic [1:0] size, input logic [31:0] wdata, output int acc);
    @(posedge clk);
    #1;
    acc = -1;
    if (who == OWNER_IF) begin
      if_addr = addr;
      if_req_valid = 1'b1;
    end else begin
      ls_addr = addr; ls_we = we; ls_size = size; ls_wdata = wdata;
      ls_req_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((who == OWNER_IF) ? if_req_ready : ls_req_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    tests_run++;
    if (acc < 0) begin
      tests_failed++;
      $display("FAIL accept_timeout: port %0d addr %h not accepted within 20 cycles", who, addr);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_error, ls_rsp_error} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_error, ls_rsp_error});
    end
    tests_run++;
    if (mc_address !== 32'h0 || mc_data_in !== 32'h0 || mc_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mc: got addr=%h din=%h we=%b expected 0", mc_address, mc_data_in, mc_write_enable);
    end
    tests_run++;
    if (mc_data_in_size !== SIZE_WORD || mc_data_out_size !== SIZE_WORD) begin
      tests_failed++;
      $display("FAIL reset_sizes: got %b/%b expected 10/10", mc_data_in_size, mc_data_out_size);
    end
    tests_run++;
    if (err_count !== '0 || if_rsp_data !== 32'h0 || ls_rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: got err_count=%0d if_data=%h ls_data=%h expected 0",
               err_count, if_rsp_data, ls_rsp_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    int acc;
    issue(OWNER_IF, 32'h10, 1'b0, SIZE_WORD, 32'h0, acc);
    @(negedge clk);
    tests_run++;
    if (mc_address !== 32'h10 || mc_write_enable !== 1'b0 ||
        mc_data_in_size !== SIZE_WORD || mc_data_out_size !== SIZE_WORD) begin
      tests_failed++;
      $display("FAIL if_access: got addr=%h we=%b sizes=%b/%b expected 00000010 0 10/10",
               mc_address, mc_write_enable, mc_data_in_size, mc_data_out_size);
    end
    wait_idle();
  endtask

  task automatic test_ls_write_read();
    int acc;
    we_cycles.delete();
    issue(OWNER_LS, 32'h100, 1'b1, SIZE_WORD, 32'hDEAD_BEEF, acc);
    @(negedge clk);
    tests_run++;
    if (mc_address !== 32'h100 || mc_data_in !== 32'hDEAD_BEEF || mc_data_in_size !== SIZE_WORD) begin
      tests_failed++;
      $display("FAIL ls_write_access: got addr=%h din=%h size=%b expected 00000100 deadbeef 10",
               mc_address, mc_data_in, mc_data_in_size);
    end
    wait_idle();
    tests_run++;
    if (we_cycles.size() != 1 || we_cycles[0] != acc + 1) begin
      tests_failed++;
      $display("FAIL ls_write_we_window: got %0d we cycles first=%0d expected 1 at %0d",
               we_cycles.size(), (we_cycles.size() != 0) ? we_cycles[0] : -1, acc + 1);
    end
    issue(OWNER_LS, 32'h100, 1'b0, SIZE_WORD, 32'h0, acc);
    wait_idle();
    issue(OWNER_LS, 32'h104, 1'b1, SIZE_BYTE, 32'h0000_00AB, acc);
    @(negedge clk);
    tests_run++;
    if (mc_data_in_size !== SIZE_BYTE || mc_data_out_size !== SIZE_BYTE) begin
      tests_failed++;
      $display("FAIL ls_byte_size: got %b/%b expected 00/00", mc_data_in_size, mc_data_out_size);
    end
    wait_idle();
  endtask

  task automatic test_contention();
    arb_owner_t got[$];
    arb_owner_t want[4];
    logic       if_seen;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    want = '{OWNER_LS, OWNER_IF, OWNER_LS, OWNER_IF};
`else
    want = '{OWNER_LS, OWNER_LS, OWNER_LS, OWNER_LS};
`endif
    if_seen = 1'b0;
    do_reset();
    @(posedge clk);
    #1;
    if_addr = 32'h10;
    ls_addr = 32'h100; ls_we = 1'b0; ls_size = SIZE_WORD;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    for (int i = 0; i < 40 && got.size() < 4; i++) begin
      @(negedge clk);
      if (if_req_ready) if_seen = 1'b1;
      if (ls_req_ready)      got.push_back(OWNER_LS);
      else if (if_req_ready) got.push_back(OWNER_IF);
    end
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= got.size() || got[i] !== want[i]) begin
        tests_failed++;
        $display("FAIL contention_order[%0d]: got %0d expected %0d", i,
                 (i < got.size()) ? int'(got[i]) : -1, want[i]);
      end
    end
`ifndef MEM_ARB_ROUND_ROBIN_EN
    tests_run++;
    if (if_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_if_starve: got if_req_ready=1 expected never high");
    end
`endif
    wait_idle();
  endtask

  task automatic test_error_count();
    int acc;
    do_reset();
    issue(OWNER_LS, 32'h20, 1'b1, SIZE_WORD, 32'h1111_2222, acc);
    wait_idle();
    tests_run++;
    if (err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL err_count_first: got %0d expected 1", err_count);
    end
    for (int i = 1; i < 300; i++) begin
      issue(OWNER_LS, 32'h20, 1'b1, SIZE_WORD, 32'h1111_2222, acc);
    end
    wait_idle();
    tests_run++;
    if (err_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL err_count_saturate: got %0d expected 255", err_count);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    issue(OWNER_LS, 32'h200, 1'b1, SIZE_WORD, 32'h5555_AAAA, acc);
    tests_run++;
    if (mc_write_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_we_before: got %b expected 1", mc_write_enable);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mc_write_enable !== 1'b0 || ls_rsp_valid !== 1'b0 || err_count !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got we=%b ls_rsp_valid=%b err_count=%0d expected 0 0 0",
               mc_write_enable, ls_rsp_valid, err_count);
    end
    repeat (3) @(negedge clk);
    issue(OWNER_LS, 32'h200, 1'b0, SIZE_WORD, 32'h0, acc);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [31:0] addrs[3];
    addrs = '{32'h100, 32'h104, 32'h108};
    @(posedge clk);
    #1;
    ls_addr = addrs[0]; ls_we = 1'b0; ls_size = SIZE_WORD;
    ls_req_valid = 1'b1;
    for (int i = 0; i < 30 && acc.size() < 3; i++) begin
      @(negedge clk);
      if (ls_req_ready) begin
        acc.push_back(cyc);
        @(posedge clk);
        #1;
        if (acc.size() < 3) ls_addr = addrs[acc.size()];
        else                ls_req_valid = 1'b0;
      end
    end
    ls_req_valid = 1'b0;
    tests_run++;
    if (acc.size() != 3 || acc[1] != acc[0] + 2 || acc[2] != acc[0] + 4) begin
      tests_failed++;
      $display("FAIL back_to_back_accepts: got %0d accepts first=%0d expected 3 spaced by 2",
               acc.size(), (acc.size() != 0) ? acc[0] : -1);
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ctrl_mem[i] = 32'hC0DE_0000 | 32'(i);
      exp_mem[i]  = 32'hC0DE_0000 | 32'(i);
    end
    ctrl_mem[4] = 32'h1234_5678;
    exp_mem[4]  = 32'h1234_5678;

    test_reset();
    test_if_read();
    test_ls_write_read();
    test_contention();
    test_error_count();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port sequencer in front of `MemoryController`: shares the single combinational memory-controller access port between the instruction-fetch (IF) and load/store (LS) requesters. Accepts one request per handshake, presents it to the controller for exactly one ACCESS cycle, registers read data and the error flag, and returns a one-cycle response to the granted requester. Guarantees `mc_write_enable` is asserted only in ACCESS, only for LS writes.

## Interface
Parameters:
- `ERR_CNT_W`, 8, width of saturating error counter.

Ports (one clock `clk`; reset `rst_n` is synchronous, active-low):
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `if_req_valid` in 1: fetch request; always a word read.
- `if_req_ready` out 1: fetch request accepted this cycle when both high.
- `if_addr` in 32: fetch byte address.
- `if_rsp_valid` out 1: one-cycle fetch response strobe.
- `if_rsp_data` out 32: fetch read data.
- `if_rsp_error` out 1: controller flagged error.
- `ls_req_valid` in 1; `ls_req_ready` out 1: LS handshake.
- `ls_addr` in 32; `ls_we` in 1; `ls_size` in 2 (00 byte, 01 half, 10 word); `ls_wdata` in 32.
- `ls_rsp_valid` out 1; `ls_rsp_data` out 32; `ls_rsp_error` out 1.
- `mc_address` out 32; `mc_write_enable` out 1; `mc_data_in_size` out 2; `mc_data_out_size` out 2; `mc_data_in` out 32: to controller.
- `mc_data_out` in 32; `mc_memory_error` in 1: from controller (combinational on `mc_*`).
- `err_count` out ERR_CNT_W: saturating count of errored accesses.

## Operation
- States: IDLE, ACCESS, RESP.
- Accept window: state IDLE or RESP. Grant chosen combinationally among valid requesters; ready high only for the granted requester in the accept window; zero otherwise. Ready may depend on valid; requesters must not make valid depend on ready.
- On accept: latch owner, addr, we (IF: 0), size (IF: 10), wdata (IF: 0) into request register; next state ACCESS.
- ACCESS: drive `mc_*` from request register; `mc_data_in_size` = `mc_data_out_size` = latched size; `mc_write_enable` = latched we. At end of cycle, capture `mc_data_out`, `mc_memory_error`; next state RESP.
- RESP: owner's `rsp_valid` high exactly one cycle with captured data/error; other port's rsp_valid low. No response back-pressure; requester must take it. If a new request accepted this cycle, next ACCESS; else IDLE.
- Outside ACCESS: `mc_address`, `mc_data_in`, `mc_write_enable` = 0; sizes = 10.
- Write responses: data = captured value (controller returns 0); error valid.
- `err_count` increments on each RESP with error; saturates at all-ones, never wraps.

## Timing
- Reset (cycle with `rst_n` low at edge): state IDLE; all outputs 0 except sizes 10; `err_count` 0; request/response registers cleared. Reset in ACCESS or RESP drops the transaction, no response, write enable low from next cycle.
- Latency: accept at cycle N, ACCESS N+1, rsp_valid N+2.
- Throughput: back-to-back accepts yield one access per 2 cycles.
- Simultaneous valid: see Configuration. Single valid is always granted in the accept window.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin; `last_owner` register (reset IF) records each accept; on contention grant goes to the port not equal to `last_owner`.
- Undefined: fixed priority, LS over IF; IF may starve under continuous LS traffic (accepted).

## Structure
- Package `pisa_mem_pkg`: `arb_state_t` (IDLE, ACCESS, RESP), `arb_owner_t` (OWNER_IF, OWNER_LS), size constants `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
- Sub-module `mem_arb_grant`: inputs both valids, accept window, `last_owner`; outputs grant one-hot; holds the macro-dependent policy.

## Test plan
- IF valid at 0x10, controller returns 0x1234_5678 -> IF ready cycle N, `mc_address`=0x10 at N+1, `if_rsp_valid` and data 0x1234_5678 at N+2, error 0.
- LS write 0x100, size 10, data 0xDEADBEEF -> `mc_write_enable` high only at N+1; then LS read 0x100 returns 0xDEADBEEF, error 0.
- IF and LS valid together for 4 accepts -> with macro order LS, IF, LS, IF (after reset, last_owner=IF); without, LS every time, IF ready never high.
- LS write to 0x20 (code region), controller errors -> `ls_rsp_error`=1, `err_count` 0→1; 300 errored accesses -> `err_count`=255.
- `rst_n` low during ACCESS of an LS write -> no `ls_rsp_valid`, `mc_write_enable` 0 following cycle, state IDLE, `err_count` 0.
- Back-to-back LS reads with valid held -> accepts at N, N+2, N+4; responses at N+2, N+4, N+6.
